// File: rtl/imem_loader_pkg.sv
// Shared constants for the boot loader and the instruction memory it feeds.
// Contents:
//   WORD_W, BYTE_W         instruction word and stream byte widths
//   DEF_ADDR_W, DEF_DEPTH  instruction memory geometry, shared with the imem
//   state_t                loader FSM states
package imem_loader_pkg;

  localparam int WORD_W     = 16;
  localparam int BYTE_W     = 8;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_WRITE,
    ST_CHK,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Byte-pair assembler for the program loader.
// Keeps the low byte of a little-endian pair and presents the full 16-bit
// word combinationally while the high byte is on the bus. Also keeps the
// running XOR of every accepted byte of the frame.
// Ports:
//   clk, rst    clock and asynchronous active-low reset
//   clear       restart the running XOR for a new frame
//   en          a byte is accepted this cycle
//   lo_sel      the accepted byte is the low half of a pair
//   in_data     stream byte
//   word        {in_data, stored low byte}
//   xor_next    running XOR including in_data
module imem_loader_byte_pair_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              lo_sel,
  input  logic [BYTE_W-1:0] in_data,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] xor_next
);

  logic [BYTE_W-1:0] lo_q;
  logic [BYTE_W-1:0] xor_q;

  // Capture the low byte of each pair so it can be joined with the high byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q <= '0;
    end else if (en && lo_sel) begin
      lo_q <= in_data;
    end
  end

  // Fold every accepted byte into the checksum; clear only at frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xor_q <= '0;
    end else if (clear) begin
      xor_q <= '0;
    end else if (en) begin
      xor_q <= xor_next;
    end
  end

  assign word     = {in_data, lo_q};
  assign xor_next = xor_q ^ in_data;

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader for the 16-bit core's instruction memory.
// Accepts a byte stream (count, little-endian words, XOR checksum), writes
// the words to consecutive imem addresses from 0 and holds the core in
// reset until a frame with a good checksum has been loaded.
// Ports:
//   clk, rst               clock and asynchronous active-low reset
//   start                  begin a load (honoured in IDLE, RUN, ERR)
//   in_data/valid/ready    byte stream handshake
//   imem_we/addr/data      instruction memory write port
//   core_rst               synchronous reset to the core, low only in RUN
//   done, error            load outcome flags
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_data,
  output logic              core_rst,
  output logic              done,
  output logic              error
);

  // Count and index comparisons are done one bit wider than the 16-bit count
  // so that DEPTH itself is representable and N == DEPTH is legal.
  localparam logic [WORD_W:0] DEPTH_EXT = (WORD_W + 1)'(DEPTH);

  state_t            state;
  state_t            next_state;
  logic              xfer;
  logic              start_load;
  logic              lo_sel;
  logic              last_word;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [WORD_W-1:0] n_q;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] xor_next;

  assign xfer       = in_valid && in_ready;
  assign start_load = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
  assign lo_sel     = (state == ST_CNT_LO) || (state == ST_DATA_LO);
  assign idx_inc    = idx + 1'b1;
  assign last_word  = ((WORD_W + 1)'(idx_inc) == {1'b0, n_q});

  imem_loader_byte_pair_assembler u_byte_pair_assembler (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_load),
    .en       (xfer),
    .lo_sel   (lo_sel),
    .in_data  (in_data),
    .word     (word),
    .xor_next (xor_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The count is checked against DEPTH as soon as its high
  // byte arrives, so an oversized frame never touches memory.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_RUN, ST_ERR: if (start) next_state = ST_CNT_LO;
      ST_CNT_LO:  if (xfer) next_state = ST_CNT_HI;
      ST_CNT_HI: begin
        if (xfer) begin
          if ({1'b0, word} > DEPTH_EXT) next_state = ST_ERR;
          else if (word == '0)          next_state = ST_CHK;
          else                          next_state = ST_DATA_LO;
        end
      end
      ST_DATA_LO: if (xfer) next_state = ST_DATA_HI;
      ST_DATA_HI: if (xfer) next_state = ST_WRITE;
      ST_WRITE:   next_state = last_word ? ST_CHK : ST_DATA_LO;
      ST_CHK: begin
        if (xfer) next_state = (xor_next == '0) ? ST_RUN : ST_ERR;
      end
      default:    next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded purely from the state register so in_ready never
  // depends on in_valid.
  always_comb begin
    in_ready = 1'b0;
    imem_we  = 1'b0;
    core_rst = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      ST_CNT_LO, ST_CNT_HI, ST_DATA_LO, ST_DATA_HI, ST_CHK: in_ready = 1'b1;
      ST_WRITE: imem_we = 1'b1;
      ST_RUN: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  // Word index: cleared at frame start, advanced once per write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (start_load) begin
      idx <= '0;
    end else if (state == ST_WRITE) begin
      idx <= idx_inc;
    end
  end

  // Word count captured when its high byte arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q <= '0;
    end else if ((state == ST_CNT_HI) && xfer) begin
      n_q <= word;
    end
  end

  // Write address and data are loaded on the high byte so they are stable
  // during WRITE, and they hold their values afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_addr <= '0;
      imem_data <= '0;
    end else if ((state == ST_DATA_HI) && xfer) begin
      imem_addr <= idx[ADDR_W-1:0];
      imem_data <= word;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized
// frames with stream gaps, checked against a frame-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0] imem_data;
  logic        core_rst;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [31:0] seen[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .core_rst  (core_rst),
    .done      (done),
    .error     (error)
  );

  // Record every memory write seen on the write port.
  always @(negedge clk) begin
    if (imem_we === 1'b1) seen.push_back({4'h0, imem_addr, imem_data});
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then the loader should be waiting for the count byte.
  task automatic do_start();
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen.delete();
    check_output("start_core_rst", {31'd0, core_rst}, 32'd1);
    check_output("start_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("start_flags", {30'd0, done, error}, 32'd0);
  endtask

  // Push bytes through the handshake with optional idle gaps; in gaps a
  // stray start pulse may be driven, which the loader must ignore mid-frame.
  task automatic apply_stimulus(input bq_t q, input int gap_max, input bit poke_start);
    int waited;
    for (int i = 0; i < q.size(); i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = poke_start && ($urandom_range(1, 0) == 1);
        @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = q[i];
      waited   = 0;
      while (in_ready !== 1'b1 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 200) begin
        check_output("byte_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Build a well-formed frame from a word list; corrupt flips checksum bits.
  function automatic bq_t make_frame(input wq_t w, input bit corrupt);
    bq_t  q;
    logic [7:0] c;
    logic [15:0] n;
    n = 16'(w.size());
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    foreach (w[i]) begin
      q.push_back(w[i][7:0]);
      q.push_back(w[i][15:8]);
    end
    c = 8'h00;
    foreach (q[i]) c ^= q[i];
    if (corrupt) c ^= 8'(1 + $urandom_range(254, 0));
    q.push_back(c);
    return q;
  endfunction

  // Reference model at frame level: derive expected writes and outcome
  // from the bytes alone, then compare against what was observed.
  task automatic check_frame(input string name, input bq_t q);
    logic [31:0] exp[$];
    logic [15:0] n;
    logic [7:0]  x;
    bit          exp_done;
    int          m;
    n = {q[1], q[0]};
    exp_done = 1'b0;
    if (int'(n) <= DEPTH) begin
      for (int i = 0; i < int'(n); i++) begin
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(i);
        exp.push_back({4'h0, a, q[3 + 2*i], q[2 + 2*i]});
      end
      x = 8'h00;
      foreach (q[i]) x ^= q[i];
      exp_done = (x == 8'h00);
    end
    repeat (3) @(negedge clk);
    check_output({name, "_write_count"}, 32'(seen.size()), 32'(exp.size()));
    m = (seen.size() < exp.size()) ? seen.size() : exp.size();
    for (int i = 0; i < m; i++)
      check_output($sformatf("%s_write%0d", name, i), seen[i], exp[i]);
    check_output({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check_output({name, "_error"}, {31'd0, error}, {31'd0, !exp_done});
    check_output({name, "_core_rst"}, {31'd0, core_rst}, {31'd0, !exp_done});
    check_output({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    bq_t q;
    wq_t w;

    $display("[TB] imem_loader bench starting");
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    #12;
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("reset_core_rst", {31'd0, core_rst}, 32'd1);
    check_output("reset_flags", {29'd0, imem_we, done, error}, 32'd0);
    check_output("reset_addr_data", {4'h0, imem_addr, imem_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Two-word frame with a good checksum.
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h34};
    do_start();
    apply_stimulus(q, 0, 1'b0);
    check_frame("good2", q);

    // Same frame with a bad checksum: writes still happen, then ERR.
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h37, 8'h12, 8'h35};
    do_start();
    apply_stimulus(q, 0, 1'b0);
    check_frame("badchk", q);

    // Reset asserted between the low and high byte of a word.
    q = '{8'h02, 8'h00, 8'h11};
    do_start();
    apply_stimulus(q, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_output("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("midrst_core_rst", {31'd0, core_rst}, 32'd1);
    check_output("midrst_flags", {29'd0, imem_we, done, error}, 32'd0);
    check_output("midrst_addr_data", {4'h0, imem_addr, imem_data}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check_output("midrst_no_write", 32'(seen.size()), 32'd0);

    // Fresh one-word frame after the reset lands at address 0.
    q = '{8'h01, 8'h00, 8'hAA, 8'h55, 8'hFE};
    do_start();
    apply_stimulus(q, 0, 1'b0);
    check_frame("after_rst", q);

    // Oversized count: straight to ERR, nothing written.
    q = '{8'h01, 8'h10};
    do_start();
    apply_stimulus(q, 0, 1'b0);
    check_frame("too_big", q);

    // Empty program.
    q = '{8'h00, 8'h00, 8'h00};
    do_start();
    apply_stimulus(q, 0, 1'b0);
    check_frame("empty", q);

    // Random frames with stream gaps and stray start pulses.
    for (int t = 0; t < 8; t++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) w.push_back(16'($urandom));
      q = make_frame(w, $urandom_range(3, 0) == 0);
      do_start();
      apply_stimulus(q, 3, 1'b1);
      check_frame($sformatf("rand%0d", t), q);
    end

    // Full-depth program: last write at the top address, no wrap.
    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back(16'($urandom));
    q = make_frame(w, 1'b0);
    do_start();
    apply_stimulus(q, 0, 1'b0);
    check_frame("full", q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
